// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: constants and types shared by the fetch front end.
//   NOP_INSTR_C   bubble word driven when no valid instruction is available
//   RESET_PC_C    first fetch address after reset
//   HALT_OPCODE_C opcode of the HALT instruction (decoded upstream)
//   fetch_state_e fetch FSM state encoding
//   ibuf_entry_t  one instruction-buffer entry {instr, pc_inc2}
package fetch_unit_pkg;

  localparam logic [15:0] NOP_INSTR_C   = 16'h0800;
  localparam logic [15:0] RESET_PC_C    = 16'h0000;
  localparam logic [4:0]  HALT_OPCODE_C = 5'b00000;

  typedef enum logic [1:0] {
    ST_START  = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } fetch_state_e;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc_inc2;
  } ibuf_entry_t;

  // Next sequential halfword-aligned address; wraps 16'hFFFE -> 16'h0000.
  function automatic logic [15:0] pc_plus2(input logic [15:0] pc);
    return pc + 16'd2;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO with flush, used as the instruction
// buffer and as the in-flight address tag queue.
//   clk    in   clock
//   rst    in   asynchronous active-low reset
//   push   in   write wdata (ignored when full)
//   wdata  in   write data
//   pop    in   drop the head entry (ignored when empty)
//   flush  in   empty the FIFO; wins over push/pop in the same cycle
//   rdata  out  head entry (valid when !empty)
//   count  out  number of stored entries
//   empty  out  count == 0
module fetch_fifo
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Pointer increment that also works for non-power-of-two depths.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) begin
      return AW'(0);
    end else begin
      return p + AW'(1);
    end
  endfunction

  assign empty     = (count_q == CW'(0));
  assign push_ok_s = push && (count_q != CW'(DEPTH));
  assign pop_ok_s  = pop && !empty;
  assign rdata     = mem_q[rd_ptr_q];
  assign count     = count_q;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
    end else if (flush) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
    end else begin
      if (push_ok_s) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_ok_s)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else if (push_ok_s && !flush) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end feeding the decode stage.
//   clk          in   clock
//   rst          in   asynchronous active-low reset
//   stall        in   decode stall: hold instr/pc_inc2/instr_valid
//   redirect     in   taken branch/jump: refetch from redirect_pc
//   redirect_pc  in   new fetch address (bit 0 forced to 0)
//   halt         in   stop fetching (terminal until reset)
//   imem_req     out  instruction memory read request
//   imem_addr    out  read address (current fetch pc)
//   imem_gnt     in   request accepted this cycle
//   imem_rvalid  in   read data valid (in request order)
//   imem_rdata   in   read data
//   instr        out  instruction to decode
//   pc_inc2      out  address of instr + 2
//   instr_valid  out  instr is a real fetched word
//   err          out  sticky: rvalid seen with nothing outstanding
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          IBUF_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [15:0] RESET_PC        = RESET_PC_C,
  parameter logic [15:0] NOP_INSTR       = NOP_INSTR_C
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr,
  output logic [15:0] pc_inc2,
  output logic        instr_valid,
  output logic        err
);

  localparam int BCW = $clog2(IBUF_DEPTH + 1);
  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);

  fetch_state_e  state_q, state_d;
  logic [15:0]   fetch_pc_q, fetch_pc_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [OW-1:0] drop_q, drop_d;
  logic [15:0]   instr_q, instr_d;
  logic [15:0]   pc_inc2_q, pc_inc2_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  logic          in_run_s, redirect_s, halt_now_s;
  logic          req_s, hs_s, rv_ok_s;
  logic          buf_push_s, buf_pop_s, buf_flush_s, buf_empty_s;
  logic [BCW-1:0] buf_cnt_s;
  ibuf_entry_t   buf_wdata_s, buf_rdata_s;
  logic [15:0]   tag_s;
  logic [OW-1:0] unused_tag_cnt_s;
  logic          unused_tag_empty_s;
  logic          unused_rpc0_s;

  assign unused_rpc0_s = redirect_pc[0];

  assign in_run_s   = (state_q == ST_RUN);
  // Redirect is honoured in START and RUN, ignored once halted.
  assign redirect_s = redirect && (state_q != ST_HALTED);
  assign halt_now_s = in_run_s && halt && !stall && !redirect;

  // Credit rule: every outstanding request owns a free buffer slot, so a
  // returning word always fits.
  assign req_s = in_run_s && !redirect
              && ((int'(outst_q) + int'(buf_cnt_s)) < IBUF_DEPTH)
              && (int'(outst_q) < MAX_OUTSTANDING);
  assign hs_s    = req_s && imem_gnt;
  assign rv_ok_s = imem_rvalid && (outst_q != OW'(0));

  // Words are discarded while older squashed fetches are still draining,
  // in the redirect cycle itself, and whenever the unit is not running.
  assign buf_push_s  = rv_ok_s && (drop_q == OW'(0)) && in_run_s && !redirect;
  assign buf_pop_s   = in_run_s && !redirect && !stall && !halt && !buf_empty_s;
  assign buf_flush_s = redirect_s || halt_now_s || (state_q == ST_HALTED);

  assign buf_wdata_s.instr   = imem_rdata;
  assign buf_wdata_s.pc_inc2 = pc_plus2(tag_s);

  fetch_fifo #(.WIDTH(16), .DEPTH(MAX_OUTSTANDING)) u_tag_q (
    .clk   (clk),
    .rst   (rst),
    .push  (hs_s),
    .wdata (fetch_pc_q),
    .pop   (rv_ok_s),
    .flush (1'b0),
    .rdata (tag_s),
    .count (unused_tag_cnt_s),
    .empty (unused_tag_empty_s)
  );

  fetch_fifo #(.WIDTH($bits(ibuf_entry_t)), .DEPTH(IBUF_DEPTH)) u_ibuf (
    .clk   (clk),
    .rst   (rst),
    .push  (buf_push_s),
    .wdata (buf_wdata_s),
    .pop   (buf_pop_s),
    .flush (buf_flush_s),
    .rdata (buf_rdata_s),
    .count (buf_cnt_s),
    .empty (buf_empty_s)
  );

  // Next-state logic for the FSM, counters, fetch pc and output register.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    instr_d    = instr_q;
    pc_inc2_d  = pc_inc2_q;
    valid_d    = valid_q;
    err_d      = err_q | (imem_rvalid && (outst_q == OW'(0)));

    case ({hs_s, rv_ok_s})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   outst_d = outst_q - OW'(1);
      default: outst_d = outst_q;
    endcase

    // On redirect every request still in flight after this cycle is stale.
    if (redirect_s) begin
      drop_d = rv_ok_s ? (outst_q - OW'(1)) : outst_q;
    end else if (rv_ok_s && (drop_q != OW'(0))) begin
      drop_d = drop_q - OW'(1);
    end else begin
      drop_d = drop_q;
    end

    if (redirect_s) begin
      fetch_pc_d = {redirect_pc[15:1], 1'b0};
    end else if (hs_s) begin
      fetch_pc_d = pc_plus2(fetch_pc_q);
    end else begin
      fetch_pc_d = fetch_pc_q;
    end

    case (state_q)
      ST_START:  state_d = ST_RUN;
      ST_RUN: begin
        if (halt_now_s) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_HALTED;
    endcase

    // Output priority: redirect/halt bubble > stall hold > normal pop.
    if (redirect_s || halt_now_s || (state_q == ST_HALTED)) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (stall) begin
      instr_d   = instr_q;
      pc_inc2_d = pc_inc2_q;
      valid_d   = valid_q;
    end else if (buf_pop_s) begin
      instr_d   = buf_rdata_s.instr;
      pc_inc2_d = buf_rdata_s.pc_inc2;
      valid_d   = 1'b1;
    end else begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  // State register for the whole fetch unit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_START;
      fetch_pc_q <= RESET_PC;
      outst_q    <= OW'(0);
      drop_q     <= OW'(0);
      instr_q    <= NOP_INSTR;
      pc_inc2_q  <= 16'h0000;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      instr_q    <= instr_d;
      pc_inc2_q  <= pc_inc2_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign imem_req    = req_s;
  assign imem_addr   = fetch_pc_q;
  assign instr       = instr_q;
  assign pc_inc2     = pc_inc2_q;
  assign instr_valid = valid_q;
  assign err         = err_q;

endmodule
